// File: rtl/adc_avg_if.sv
// adc_avg_if: sample/channel inputs and average/status outputs of the ADC moving-average filter
interface adc_avg_if #(
    parameter int DATA_W = 12
);
    logic [DATA_W-1:0] sample_in;
    logic              sample_valid;
    logic [2:0]        chan_sel;
    logic [DATA_W-1:0] avg_out;
    logic              avg_valid;
    logic              filled;
    logic              busy;
    modport master (output sample_in, sample_valid, chan_sel, input avg_out, avg_valid, filled, busy);
    modport slave  (input sample_in, sample_valid, chan_sel, output avg_out, avg_valid, filled, busy);
endinterface

// File: rtl/adc_avg_filter.sv
// adc_avg_filter: boxcar average over the last 2^LOG2_DEPTH samples, flushed on channel change.
// Define ADC_AVG_ROUND_EN for round-half-up instead of truncation.
module adc_avg_filter #(
    parameter int DATA_W     = 12,
    parameter int LOG2_DEPTH = 3
) (
    input logic     clk,
    input logic     reset_n,
    adc_avg_if.slave bus
);
    localparam int DEPTH = 1 << LOG2_DEPTH;
    localparam int SW    = DATA_W + LOG2_DEPTH;
    localparam int CW    = LOG2_DEPTH + 1;
`ifdef ADC_AVG_ROUND_EN
    localparam logic [SW-1:0] RND = SW'(DEPTH / 2);
`else
    localparam logic [SW-1:0] RND = '0;
`endif
    typedef enum logic {FLUSH, RUN} state_t;
    state_t                state_q, state_d;
    logic [DATA_W-1:0]     mem [DEPTH];
    logic [LOG2_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [SW-1:0]         sum_q, sum_d, sum_next;
    logic [CW-1:0]         count_q, count_d;
    logic [2:0]            chan_q;
    logic [DATA_W-1:0]     avg_out_q, avg_out_d;
    logic                  avg_valid_q, avg_valid_d;
    logic                  filled_q, filled_d;
    logic                  busy_q, busy_d;
    logic                  change, accept;
    always_comb begin
        change      = bus.chan_sel != chan_q;
        accept      = state_q == RUN && bus.sample_valid && !change;
        // oldest slot is already part of sum_q, so this never underflows
        sum_next    = sum_q + SW'(bus.sample_in) - SW'(mem[wr_ptr_q]);
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        sum_d       = sum_q;
        count_d     = count_q;
        avg_out_d   = avg_out_q;
        avg_valid_d = 1'b0;
        if (change) begin
            state_d  = FLUSH;
            wr_ptr_d = '0;
        end else if (state_q == FLUSH) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            state_d  = &wr_ptr_q ? RUN : FLUSH;
        end else if (accept) begin
            wr_ptr_d    = wr_ptr_q + 1'b1;
            sum_d       = sum_next;
            count_d     = count_q == CW'(DEPTH) ? count_q : count_q + 1'b1;
            avg_out_d   = DATA_W'((sum_next + RND) >> LOG2_DEPTH);
            avg_valid_d = 1'b1;
        end
        if (state_d == FLUSH) begin
            sum_d   = '0;
            count_d = '0;
        end
        filled_d = count_d == CW'(DEPTH);
        busy_d   = state_d == FLUSH;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= FLUSH;
            wr_ptr_q    <= '0;
            sum_q       <= '0;
            count_q     <= '0;
            chan_q      <= '0;
            avg_out_q   <= '0;
            avg_valid_q <= 1'b0;
            filled_q    <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            sum_q       <= sum_d;
            count_q     <= count_d;
            chan_q      <= bus.chan_sel;
            avg_out_q   <= avg_out_d;
            avg_valid_q <= avg_valid_d;
            filled_q    <= filled_d;
            busy_q      <= busy_d;
        end
    end
    // history has no reset so it can map onto RAM; the flush clears it instead
    always_ff @(posedge clk) begin
        if (state_q == FLUSH)
            mem[wr_ptr_q] <= '0;
        else if (accept)
            mem[wr_ptr_q] <= bus.sample_in;
    end
    assign bus.avg_out   = avg_out_q;
    assign bus.avg_valid = avg_valid_q;
    assign bus.filled    = filled_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_adc_avg_filter.sv
// tb_adc_avg_filter: directed plus random checks of adc_avg_filter against a queue-based window model
module tb_adc_avg_filter;
    localparam int DEPTH = 8;
    logic clk;
    logic reset_n;
    adc_avg_if #(.DATA_W(12)) bus ();
    adc_avg_filter #(.DATA_W(12), .LOG2_DEPTH(3)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
    int n_chk = 0;
    int n_err = 0;
    int hist[$];
    int cnt;
    int avg_m;
    int hold;
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask
    function automatic void m_flush();
        hist.delete();
        for (int i = 0; i < DEPTH; i++) hist.push_back(0);
        cnt = 0;
    endfunction
    function automatic void m_accept(input int v);
        int s;
        hist.push_back(v);
        void'(hist.pop_front());
        if (cnt < DEPTH) cnt++;
        s = 0;
        foreach (hist[i]) s += hist[i];
`ifdef ADC_AVG_ROUND_EN
        avg_m = (s + DEPTH / 2) / DEPTH;
`else
        avg_m = s / DEPTH;
`endif
    endfunction
    task automatic send(input int v, input string tag);
        bus.sample_in = 12'(v);
        bus.sample_valid = 1'b1;
        tick();
        bus.sample_valid = 1'b0;
        m_accept(v);
        chk({tag, ".valid"}, 32'(bus.avg_valid), 1);
        chk({tag, ".avg"}, 32'(bus.avg_out), 32'(avg_m));
        chk({tag, ".filled"}, 32'(bus.filled), 32'(cnt == DEPTH));
    endtask
    task automatic wait_run(input bit strobe, input int exp_cyc, input string tag);
        int n = 0;
        while (bus.busy === 1'b1 && n < 50) begin
            if (strobe) begin
                bus.sample_in = 12'($urandom_range(0, 4095));
                bus.sample_valid = 1'b1;
            end
            tick();
            n++;
            chk({tag, ".novalid"}, 32'(bus.avg_valid), 0);
        end
        bus.sample_valid = 1'b0;
        chk({tag, ".flush_cycles"}, 32'(n), 32'(exp_cyc));
        chk({tag, ".filled"}, 32'(bus.filled), 0);
        m_flush();
    endtask
    initial begin
        reset_n = 1'b0;
        bus.sample_in = '0;
        bus.sample_valid = 1'b0;
        bus.chan_sel = 3'd0;
        m_flush();
        repeat (3) tick();
        chk("rst.avg", 32'(bus.avg_out), 0);
        chk("rst.valid", 32'(bus.avg_valid), 0);
        chk("rst.filled", 32'(bus.filled), 0);
        chk("rst.busy", 32'(bus.busy), 1);
        reset_n = 1'b1;
        wait_run(1'b0, 8, "init");
        // warm-up ramp and fill
        send(1000, "s1.first");
        chk("s1.const125", 32'(bus.avg_out), 125);
        tick();
        chk("s1.pulse_once", 32'(bus.avg_valid), 0);
        for (int i = 0; i < 7; i++) send(1000, "s1.fill");
        chk("s1.const1000", 32'(bus.avg_out), 1000);
        chk("s1.filled", 32'(bus.filled), 1);
        send(2000, "s2.wrap");
        chk("s2.const1125", 32'(bus.avg_out), 1125);
        for (int i = 0; i < 8; i++) send(4095, "s2.max");
        chk("s2.const4095", 32'(bus.avg_out), 4095);
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 1) == 1) tick();
            send(int'($urandom_range(0, 4095)), "rand");
        end
        // channel change together with a strobe: sample dropped, output held
        hold = int'(bus.avg_out);
        bus.chan_sel = 3'd3;
        bus.sample_in = 12'd777;
        bus.sample_valid = 1'b1;
        tick();
        bus.sample_valid = 1'b0;
        chk("s4.busy", 32'(bus.busy), 1);
        chk("s4.dropped", 32'(bus.avg_valid), 0);
        chk("s4.filled", 32'(bus.filled), 0);
        wait_run(1'b1, 8, "s4");
        chk("s4.hold", 32'(bus.avg_out), 32'(hold));
        send(800, "s4.first");
        chk("s4.const100", 32'(bus.avg_out), 100);
        for (int i = 0; i < 10; i++) send(int'($urandom_range(0, 4095)), "rand2");
        // change again part-way through a flush
        bus.chan_sel = 3'd5;
        tick();
        repeat (3) tick();
        chk("s5.busy_mid", 32'(bus.busy), 1);
        bus.chan_sel = 3'd6;
        tick();
        chk("s5.busy_restart", 32'(bus.busy), 1);
        wait_run(1'b0, 8, "s5");
        send(5, "s3.small");
`ifdef ADC_AVG_ROUND_EN
        chk("s3.round", 32'(bus.avg_out), 1);
`else
        chk("s3.trunc", 32'(bus.avg_out), 0);
`endif
        for (int i = 0; i < 12; i++) send(int'($urandom_range(0, 4095)), "rand3");
        // asynchronous reset between edges
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("s6.avg", 32'(bus.avg_out), 0);
        chk("s6.valid", 32'(bus.avg_valid), 0);
        chk("s6.filled", 32'(bus.filled), 0);
        chk("s6.busy", 32'(bus.busy), 1);
        bus.chan_sel = 3'd0;
        tick();
        reset_n = 1'b1;
        wait_run(1'b0, 8, "s6");
        for (int i = 0; i < 9; i++) send(int'($urandom_range(0, 4095)), "rand4");
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
